matrix_index_counter: RTL and testbench
=======================================

Name: matrix_index_counter

Overview:
- Nested row/column index generator for matrix-vector passes in the neural-net datapath.
- Generalises the fixed 0..2 column counter to parametrised widths, run-time bounds, selectable traversal order, start/abort control, last-element flags and a completion pulse.
- Feeds weight-memory addressing and accumulator control, and advances one element per cycle while `en` is high.

Parameters:
- ROW_W, 4, width of row_index; maximum supported rows = 2^ROW_W.
- COL_W, 4, width of column_index; maximum supported columns = 2^COL_W.
- COL_MAJOR, 0, traversal order: 0 = column index is inner (fast) loop; 1 = row index is inner loop.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- clear  in  1  synchronous active-high reset; highest priority.
- start  in  1  begin a pass; bounds latched this cycle; honoured only in IDLE.
- abort  in  1  terminate the pass without a done pulse; honoured only in RUN.
- en  in  1  advance one element; honoured only in RUN.
- last_row  in  ROW_W  inclusive final row index (rows = last_row+1); sampled on accepted start.
- last_col  in  COL_W  inclusive final column index (cols = last_col+1); sampled on accepted start.
- row_index  out  ROW_W  current row, registered.
- column_index  out  COL_W  current column, registered.
- busy  out  1  registered; high in RUN.
- col_last  out  1  combinational; busy && column_index == latched last_col.
- row_last  out  1  combinational; busy && row_index == latched last_row.
- elem_last  out  1  combinational; col_last && row_last (the next en ends the pass).
- done  out  1  registered one-cycle pulse after the final element is consumed.

Behaviour:
- States: IDLE, RUN.
- clear=1: next state IDLE; row_index=0, column_index=0, latched bounds=0, busy=0, done=0. This applies in any state, including mid-pass.
- Priority in the same cycle: clear > abort > start/en.
- IDLE:
  - start=1 latches last_row/last_col, forces indices to 0, goes to RUN.
  - busy=1 and (0,0) are visible from the next cycle.
  - en and abort are ignored in IDLE.
- RUN, en=0: all state holds.
- RUN, en=1, COL_MAJOR=0:
  - If column_index != last_col: column_index+1.
  - Else column_index=0, and:
    - if row_index != last_row: row_index+1;
    - else row_index=0, next state IDLE, done=1 next cycle.
- RUN, en=1, COL_MAJOR=1: same rules with the roles of row and column swapped (row is the inner loop).
- RUN, abort=1: indices go to 0, next state IDLE, done stays 0; en is ignored that cycle.
- start during RUN is ignored; latched bounds are never changed mid-pass.
- done:
  - high for exactly one cycle, coincident with the first busy=0 cycle;
  - zero in every other cycle;
  - start may be accepted in the same cycle done is high.
- Comparisons use only the latched bounds, so input bound changes after start have no effect.
- Indices never exceed the latched bounds. Wrap is to 0 with no modular overflow, because the bounds are inclusive and within width.
- Degenerate 1x1 pass (last_row=0, last_col=0): elem_last=1 in the first RUN cycle; the first en ends the pass.
- Total en-accepted cycles per pass = (last_row+1)*(last_col+1).

Test Plan:
- Reset: clear=1 for 2 cycles mid-pass at (1,2) -> row_index=0, column_index=0, busy=0, done=0 next cycle; en alone then does nothing.
- Row-major 3x3:
  - Stimulus: start with last_row=2, last_col=2, then en held high for 9 cycles.
  - Index sequence: (0,0),(0,1),(0,2),(1,0)…(2,2).
  - col_last high at columns 2; elem_last high only at (2,2).
  - done pulses once in the cycle after the 9th en, with busy=0 in that cycle.
- Col-major 2x4 (COL_MAJOR=1):
  - Stimulus: last_row=1, last_col=3, en held high.
  - Index sequence: (0,0),(1,0),(0,1),(1,1)…(1,3).
  - done after 8 accepted en; en gaps of 3 cycles hold the indices.
- Abort and ignored start:
  - Start a 4x4 pass and abort at (1,3) -> indices (0,0), busy=0, done never asserts.
  - A start asserted during RUN with new bounds -> no effect on the running pass.
- Edge cases:
  - 1x1 pass: done one cycle after the single en.
  - Full-size 16x16 with default widths: 256 en cycles, indices reach 15/15 without overflow.
  - Back-to-back: start asserted in the done cycle -> a new pass begins with busy=1 the next cycle.

Source files
------------

// File: rtl/matrix_index_counter.sv
// Nested row/column index generator for matrix-vector passes: walks a
// (last_row+1) x (last_col+1) grid one element per enabled cycle.
module matrix_index_counter #(
    parameter int ROW_W     = 4,
    parameter int COL_W     = 4,
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             abort,
    input  logic             en,
    input  logic [ROW_W-1:0] last_row,
    input  logic [COL_W-1:0] last_col,
    output logic [ROW_W-1:0] row_index,
    output logic [COL_W-1:0] column_index,
    output logic             busy,
    output logic             col_last,
    output logic             row_last,
    output logic             elem_last,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] last_row_q, last_row_d;
    logic [COL_W-1:0] last_col_q, last_col_d;
    logic             done_q, done_d;

    logic row_at_last;
    logic col_at_last;

    assign row_at_last = (row_q == last_row_q);
    assign col_at_last = (col_q == last_col_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    last_row_d = last_row;
                    last_col_d = last_col;
                    row_d      = '0;
                    col_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = IDLE;
                end else if (en) begin
                    if (!COL_MAJOR) begin
                        // Column is the inner loop; the row steps on column wrap.
                        if (!col_at_last) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            col_d = '0;
                            if (!row_at_last) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                row_d   = '0;
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        if (!row_at_last) begin
                            row_d = row_q + 1'b1;
                        end else begin
                            row_d = '0;
                            if (!col_at_last) begin
                                col_d = col_q + 1'b1;
                            end else begin
                                col_d   = '0;
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (clear) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
            done_q     <= done_d;
        end
    end

    assign row_index    = row_q;
    assign column_index = col_q;
    assign busy         = (state_q == RUN);
    assign col_last     = busy && col_at_last;
    assign row_last     = busy && row_at_last;
    assign elem_last    = col_last && row_last;
    assign done         = done_q;

endmodule

// File: tb/tb_matrix_index_counter.sv
// Bench for matrix_index_counter: row-major and column-major instances share
// stimulus and are checked against an element-count model of the traversal.
module tb_matrix_index_counter;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] last_row = '0;
    logic [3:0] last_col = '0;

    logic [3:0] r_row, r_col, c_row, c_col;
    logic       r_busy, r_cl, r_rl, r_el, r_done;
    logic       c_busy, c_cl, c_rl, c_el, c_done;
    logic [12:0] r_obs, c_obs;

    int checks = 0;
    int errors = 0;

    // Reference model: a pass is just a count k of consumed elements.
    bit m_busy = 0;
    int m_k    = 0;
    int m_lr   = 0;
    int m_lc   = 0;
    bit m_done = 0;

    always #5 clock = ~clock;

    matrix_index_counter #(.ROW_W(4), .COL_W(4), .COL_MAJOR(1'b0)) u_row_major (
        .clock(clock), .clear(clear), .start(start), .abort(abort), .en(en),
        .last_row(last_row), .last_col(last_col),
        .row_index(r_row), .column_index(r_col), .busy(r_busy),
        .col_last(r_cl), .row_last(r_rl), .elem_last(r_el), .done(r_done)
    );

    matrix_index_counter #(.ROW_W(4), .COL_W(4), .COL_MAJOR(1'b1)) u_col_major (
        .clock(clock), .clear(clear), .start(start), .abort(abort), .en(en),
        .last_row(last_row), .last_col(last_col),
        .row_index(c_row), .column_index(c_col), .busy(c_busy),
        .col_last(c_cl), .row_last(c_rl), .elem_last(c_el), .done(c_done)
    );

    assign r_obs = {r_row, r_col, r_busy, r_cl, r_rl, r_el, r_done};
    assign c_obs = {c_row, c_col, c_busy, c_cl, c_rl, c_el, c_done};

    function automatic logic [12:0] exp_vec(input bit col_major);
        int row, col;
        bit cl, rl;
        if (col_major) begin
            row = m_k % (m_lr + 1);
            col = m_k / (m_lr + 1);
        end else begin
            row = m_k / (m_lc + 1);
            col = m_k % (m_lc + 1);
        end
        cl = m_busy && (col == m_lc);
        rl = m_busy && (row == m_lr);
        return {4'(row), 4'(col), m_busy, cl, rl, cl && rl, m_done};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic step(input bit st, input bit ab, input bit e, input bit cl,
                        input int lr, input int lc);
        start = st; abort = ab; en = e; clear = cl;
        last_row = 4'(lr); last_col = 4'(lc);
        @(posedge clock);
        m_done = 0;
        if (cl) begin
            m_busy = 0; m_k = 0; m_lr = 0; m_lc = 0;
        end else if (m_busy) begin
            if (ab) begin
                m_busy = 0; m_k = 0;
            end else if (e) begin
                m_k++;
                if (m_k == (m_lr + 1) * (m_lc + 1)) begin
                    m_busy = 0; m_k = 0; m_done = 1;
                end
            end
        end else if (st) begin
            m_busy = 1; m_k = 0; m_lr = lr; m_lc = lc;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 0);
        checks++;
        if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1)) begin
            errors++;
            $display("FAIL reset_init: got r=%h c=%h want r=%h c=%h", r_obs, c_obs, exp_vec(0), exp_vec(1));
        end
        step(1, 0, 0, 0, 2, 2);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 2, 2);
        checks++;
        if (r_row !== 4'd1 || r_col !== 4'd2 || r_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_pos: got (%0d,%0d) busy=%b want (1,2) busy=1", r_row, r_col, r_busy);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, i < 2, 2, 2);
            checks++;
            if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1)) begin
                errors++;
                $display("FAIL reset_mid_pass cyc%0d: got r=%h c=%h want r=%h c=%h", i, r_obs, c_obs, exp_vec(0), exp_vec(1));
            end
        end
    endtask

    task automatic test_row_major_3x3();
        step(1, 0, 0, 0, 2, 2);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1)) begin
                errors++;
                $display("FAIL rm3x3 cyc%0d: got r=%h c=%h want r=%h c=%h", i, r_obs, c_obs, exp_vec(0), exp_vec(1));
            end
            if (i < 9) step(0, 0, 1, 0, 2, 2);
        end
        checks++;
        if (r_done !== 1'b1 || r_busy !== 1'b0) begin
            errors++;
            $display("FAIL rm3x3_done: got done=%b busy=%b want done=1 busy=0", r_done, r_busy);
        end
        step(0, 0, 0, 0, 2, 2);
        checks++;
        if (r_done !== 1'b0) begin
            errors++;
            $display("FAIL rm3x3_done_width: got done=%b want 0", r_done);
        end
    endtask

    task automatic test_col_major_gaps();
        step(1, 0, 0, 0, 1, 3);
        for (int n = 0; n < 8; n++) begin
            for (int g = 0; g < 4; g++) begin
                step(0, 0, g == 0, 0, 1, 3);
                checks++;
                if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1)) begin
                    errors++;
                    $display("FAIL cm2x4 en%0d gap%0d: got r=%h c=%h want r=%h c=%h", n, g, r_obs, c_obs, exp_vec(0), exp_vec(1));
                end
            end
        end
    endtask

    task automatic test_abort_ignored_start();
        step(1, 0, 0, 0, 3, 3);
        for (int i = 0; i < 7; i++) begin
            step(i == 3, 0, 1, 0, (i == 3) ? int'($urandom_range(0, 15)) : 3,
                 (i == 3) ? int'($urandom_range(0, 15)) : 3);
            checks++;
            if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1)) begin
                errors++;
                $display("FAIL abort_run cyc%0d: got r=%h c=%h want r=%h c=%h", i, r_obs, c_obs, exp_vec(0), exp_vec(1));
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, i == 0, 1, 0, 3, 3);
            checks++;
            if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1) || r_done !== 1'b0) begin
                errors++;
                $display("FAIL abort_after cyc%0d: got r=%h c=%h want r=%h c=%h", i, r_obs, c_obs, exp_vec(0), exp_vec(1));
            end
        end
    endtask

    task automatic test_one_by_one();
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (r_el !== 1'b1 || c_el !== 1'b1 || r_obs !== exp_vec(0)) begin
            errors++;
            $display("FAIL 1x1_elem_last: got r=%h c=%h want r=%h c=%h", r_obs, c_obs, exp_vec(0), exp_vec(1));
        end
        step(0, 0, 1, 0, 0, 0);
        checks++;
        if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1) || r_done !== 1'b1) begin
            errors++;
            $display("FAIL 1x1_done: got r=%h c=%h want r=%h c=%h", r_obs, c_obs, exp_vec(0), exp_vec(1));
        end
    endtask

    task automatic test_full_size();
        bit saw_max = 0;
        step(1, 0, 0, 0, 15, 15);
        for (int i = 0; i < 256; i++) begin
            if (r_row == 4'd15 && r_col == 4'd15) saw_max = 1;
            step(0, 0, 1, 0, $urandom_range(0, 15), $urandom_range(0, 15));
            checks++;
            if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1)) begin
                errors++;
                $display("FAIL full16 en%0d: got r=%h c=%h want r=%h c=%h", i, r_obs, c_obs, exp_vec(0), exp_vec(1));
            end
        end
        checks++;
        if (!saw_max || r_done !== 1'b1 || c_done !== 1'b1) begin
            errors++;
            $display("FAIL full16_end: got saw_max=%b done=%b/%b want 1/1/1", saw_max, r_done, c_done);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0, 1, 2);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1, 2);
        step(1, 0, 1, 0, 2, 1);
        checks++;
        if (r_busy !== 1'b1 || r_obs !== exp_vec(0) || c_obs !== exp_vec(1)) begin
            errors++;
            $display("FAIL b2b_restart: got r=%h c=%h want r=%h c=%h", r_obs, c_obs, exp_vec(0), exp_vec(1));
        end
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0, 0, 0);
            checks++;
            if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1)) begin
                errors++;
                $display("FAIL b2b_second cyc%0d: got r=%h c=%h want r=%h c=%h", i, r_obs, c_obs, exp_vec(0), exp_vec(1));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 4) == 0, ($urandom % 30) == 0, ($urandom % 4) != 0,
                 ($urandom % 200) == 0, $urandom_range(0, 5), $urandom_range(0, 5));
            checks++;
            if (r_obs !== exp_vec(0) || c_obs !== exp_vec(1)) begin
                errors++;
                $display("FAIL random cyc%0d: got r=%h c=%h want r=%h c=%h", i, r_obs, c_obs, exp_vec(0), exp_vec(1));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_row_major_3x3();
        test_col_major_gaps();
        test_abort_ignored_start();
        test_one_by_one();
        test_full_size();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
